// File: rtl/rv32f_regfile.sv
// Single-precision FP register file with issue scoreboard and fcsr (fflags/frm).
// Reads are combinational with write-through bypass; all state updates on iCLK.
module rv32f_regfile #(
  parameter int unsigned NREG = 32,
  parameter int unsigned FLEN = 32
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic [$clog2(NREG)-1:0]   iRS1,
  input  logic [$clog2(NREG)-1:0]   iRS2,
  input  logic [$clog2(NREG)-1:0]   iRS3,
  output logic [FLEN-1:0]           oRS1_DATA,
  output logic [FLEN-1:0]           oRS2_DATA,
  output logic [FLEN-1:0]           oRS3_DATA,
  input  logic                      iWR_EN,
  input  logic [$clog2(NREG)-1:0]   iWR_RD,
  input  logic [FLEN-1:0]           iWR_DATA,
  input  logic [4:0]                iWR_FFLAGS,
  input  logic                      iISSUE_VALID,
  input  logic [$clog2(NREG)-1:0]   iISSUE_RD,
  input  logic                      iISSUE_WRITES_FRD,
  input  logic                      iISSUE_USES_RS1,
  input  logic                      iISSUE_USES_RS2,
  input  logic                      iISSUE_USES_RS3,
  output logic                      oISSUE_READY,
  output logic [$clog2(NREG):0]     oPENDING_CNT,
  input  logic                      iCSR_WE,
  input  logic [11:0]               iCSR_ADDR,
  input  logic [31:0]               iCSR_WDATA,
  output logic [31:0]               oCSR_RDATA,
  output logic [2:0]                oFRM,
  output logic                      oFRM_INVALID
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned CW = AW + 1;

  localparam logic [11:0] CSR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_FRM    = 12'h002;
  localparam logic [11:0] CSR_FCSR   = 12'h003;

  logic [FLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] pending_q, pending_d;
  logic [NREG-1:0] wr_mask, eff_pending;
  logic [4:0]      fflags_q, fflags_d;
  logic [2:0]      frm_q, frm_d;
  logic            accept;
  logic [CW-1:0]   pend_cnt;

  // Operand reads with bypass of a same-cycle writeback
  always_comb begin
    oRS1_DATA = regs_q[iRS1];
    oRS2_DATA = regs_q[iRS2];
    oRS3_DATA = regs_q[iRS3];
    if (iWR_EN && (iWR_RD == iRS1)) oRS1_DATA = iWR_DATA;
    if (iWR_EN && (iWR_RD == iRS2)) oRS2_DATA = iWR_DATA;
    if (iWR_EN && (iWR_RD == iRS3)) oRS3_DATA = iWR_DATA;
  end

  // Hazard check: a writeback landing this cycle already resolves its register
  always_comb begin
    wr_mask      = iWR_EN ? (NREG'(1) << iWR_RD) : '0;
    eff_pending  = pending_q & ~wr_mask;
    oISSUE_READY = !((iISSUE_USES_RS1   && eff_pending[iRS1]) ||
                     (iISSUE_USES_RS2   && eff_pending[iRS2]) ||
                     (iISSUE_USES_RS3   && eff_pending[iRS3]) ||
                     (iISSUE_WRITES_FRD && eff_pending[iISSUE_RD]));
    accept       = iISSUE_VALID && oISSUE_READY;
  end

  // Pending next state: clear on writeback, then set on accepted issue (set wins)
  always_comb begin
    pending_d = pending_q & ~wr_mask;
    if (accept && iISSUE_WRITES_FRD) pending_d[iISSUE_RD] = 1'b1;
  end

  // Population count of outstanding writebacks
  always_comb begin
    pend_cnt = '0;
    for (int unsigned i = 0; i < NREG; i++) pend_cnt = pend_cnt + CW'(pending_q[i]);
    oPENDING_CNT = pend_cnt;
  end

  // fcsr next state: CSR write first, then OR in accrued exception flags
  always_comb begin
    fflags_d = fflags_q;
    frm_d    = frm_q;
    if (iCSR_WE) begin
      case (iCSR_ADDR)
        CSR_FFLAGS: fflags_d = iCSR_WDATA[4:0];
        CSR_FRM:    frm_d    = iCSR_WDATA[2:0];
        CSR_FCSR: begin
          frm_d    = iCSR_WDATA[7:5];
          fflags_d = iCSR_WDATA[4:0];
        end
        default: ;
      endcase
    end
    if (iWR_EN) fflags_d = fflags_d | iWR_FFLAGS;
  end

  // CSR read mux and rounding-mode outputs
  always_comb begin
    case (iCSR_ADDR)
      CSR_FFLAGS: oCSR_RDATA = {27'b0, fflags_q};
      CSR_FRM:    oCSR_RDATA = {29'b0, frm_q};
      CSR_FCSR:   oCSR_RDATA = {24'b0, frm_q, fflags_q};
      default:    oCSR_RDATA = 32'b0;
    endcase
    oFRM         = frm_q;
    oFRM_INVALID = (frm_q >= 3'd5);
  end

  // Register array update
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (iWR_EN) begin
      regs_q[iWR_RD] <= iWR_DATA;
    end
  end

  // Scoreboard and fcsr state
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pending_q <= '0;
      fflags_q  <= '0;
      frm_q     <= '0;
    end else begin
      pending_q <= pending_d;
      fflags_q  <= fflags_d;
      frm_q     <= frm_d;
    end
  end

endmodule

// File: tb/tb_rv32f_regfile.sv
// Directed bench for rv32f_regfile; expectations queued at drive time, checked once outputs settle.
module tb_rv32f_regfile;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [4:0]  iRS1, iRS2, iRS3;
  logic [31:0] oRS1_DATA, oRS2_DATA, oRS3_DATA;
  logic        iWR_EN;
  logic [4:0]  iWR_RD;
  logic [31:0] iWR_DATA;
  logic [4:0]  iWR_FFLAGS;
  logic        iISSUE_VALID;
  logic [4:0]  iISSUE_RD;
  logic        iISSUE_WRITES_FRD, iISSUE_USES_RS1, iISSUE_USES_RS2, iISSUE_USES_RS3;
  logic        oISSUE_READY;
  logic [5:0]  oPENDING_CNT;
  logic        iCSR_WE;
  logic [11:0] iCSR_ADDR;
  logic [31:0] iCSR_WDATA;
  logic [31:0] oCSR_RDATA;
  logic [2:0]  oFRM;
  logic        oFRM_INVALID;

  rv32f_regfile dut (
    .iCLK(iCLK), .iRST(iRST),
    .iRS1(iRS1), .iRS2(iRS2), .iRS3(iRS3),
    .oRS1_DATA(oRS1_DATA), .oRS2_DATA(oRS2_DATA), .oRS3_DATA(oRS3_DATA),
    .iWR_EN(iWR_EN), .iWR_RD(iWR_RD), .iWR_DATA(iWR_DATA), .iWR_FFLAGS(iWR_FFLAGS),
    .iISSUE_VALID(iISSUE_VALID), .iISSUE_RD(iISSUE_RD),
    .iISSUE_WRITES_FRD(iISSUE_WRITES_FRD), .iISSUE_USES_RS1(iISSUE_USES_RS1),
    .iISSUE_USES_RS2(iISSUE_USES_RS2), .iISSUE_USES_RS3(iISSUE_USES_RS3),
    .oISSUE_READY(oISSUE_READY), .oPENDING_CNT(oPENDING_CNT),
    .iCSR_WE(iCSR_WE), .iCSR_ADDR(iCSR_ADDR), .iCSR_WDATA(iCSR_WDATA),
    .oCSR_RDATA(oCSR_RDATA), .oFRM(oFRM), .oFRM_INVALID(oFRM_INVALID)
  );

  always #5 iCLK = ~iCLK;

  localparam int K_RS1 = 0, K_RS2 = 1, K_RS3 = 2, K_RDY = 3,
                 K_CNT = 4, K_CSR = 5, K_FRM = 6, K_INV = 7;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          kind_q[$];
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] mem [32];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int k);
    case (k)
      K_RS1:   return oRS1_DATA;
      K_RS2:   return oRS2_DATA;
      K_RS3:   return oRS3_DATA;
      K_RDY:   return {31'b0, oISSUE_READY};
      K_CNT:   return {26'b0, oPENDING_CNT};
      K_CSR:   return oCSR_RDATA;
      K_FRM:   return {29'b0, oFRM};
      default: return {31'b0, oFRM_INVALID};
    endcase
  endfunction

  task automatic push(input int k, input string tag, input logic [31:0] exp);
    kind_q.push_back(k);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  // Let combinational outputs settle, then pop and compare everything queued
  task automatic drain();
    #2;
    while (exp_q.size() > 0) begin
      int          k;
      string       t;
      logic [31:0] e;
      k = kind_q.pop_front();
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check_eq(t, observe(k), e);
    end
  endtask

  task automatic idle();
    iRST = 1'b0; iRS1 = '0; iRS2 = '0; iRS3 = '0;
    iWR_EN = 1'b0; iWR_RD = '0; iWR_DATA = '0; iWR_FFLAGS = '0;
    iISSUE_VALID = 1'b0; iISSUE_RD = '0; iISSUE_WRITES_FRD = 1'b0;
    iISSUE_USES_RS1 = 1'b0; iISSUE_USES_RS2 = 1'b0; iISSUE_USES_RS3 = 1'b0;
    iCSR_WE = 1'b0; iCSR_ADDR = '0; iCSR_WDATA = '0;
  endtask

  // Clock one edge and return 1 time unit after it with inputs idle
  task automatic cyc();
    @(posedge iCLK);
    #1;
    idle();
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d, input logic [4:0] fl);
    iWR_EN = 1'b1; iWR_RD = rd; iWR_DATA = d; iWR_FFLAGS = fl;
  endtask

  task automatic issue(input logic [4:0] rd, input logic wr);
    iISSUE_VALID = 1'b1; iISSUE_RD = rd; iISSUE_WRITES_FRD = wr;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    iCSR_WE = 1'b1; iCSR_ADDR = a; iCSR_WDATA = d;
  endtask

  initial begin
    idle();
    iRST = 1'b1;
    @(posedge iCLK); #1;
    iRST = 1'b1;
    cyc();

    // Reset state
    iCSR_ADDR = 12'h003;
    push(K_CNT, "rst_cnt", 32'd0);
    push(K_RDY, "rst_ready", 32'd1);
    push(K_FRM, "rst_frm", 32'd0);
    push(K_INV, "rst_frm_inv", 32'd0);
    push(K_CSR, "rst_fcsr", 32'd0);
    push(K_RS1, "rst_f0", 32'd0);
    drain();

    // Write f5 then read; bypass on a concurrent write
    wb(5'd5, 32'h3F800000, 5'd0);
    cyc();
    iRS1 = 5'd5;
    push(K_RS1, "rd_f5", 32'h3F800000);
    drain();
    cyc();
    wb(5'd5, 32'h40000000, 5'd0); iRS2 = 5'd5; iRS3 = 5'd6;
    push(K_RS2, "bypass_rs2", 32'h40000000);
    push(K_RS3, "no_bypass_rs3", 32'd0);
    drain();
    cyc();
    iRS3 = 5'd5;
    push(K_RS3, "rd_f5_after", 32'h40000000);
    drain();

    // All 32 registers writable (including f0) and readable on all ports
    for (int i = 0; i < 32; i++) begin
      mem[i] = (32'(i) * 32'h01010101) ^ 32'hA5C3_0F96;
      wb(5'(i), mem[i], 5'd0);
      cyc();
    end
    for (int i = 0; i < 32; i += 7) begin
      iRS1 = 5'(i); iRS2 = 5'(31 - i); iRS3 = 5'((i + 3) % 32);
      push(K_RS1, "bulk_rs1", mem[i]);
      push(K_RS2, "bulk_rs2", mem[31 - i]);
      push(K_RS3, "bulk_rs3", mem[(i + 3) % 32]);
      drain();
      cyc();
    end

    // RAW: pend f3, block reader, release by same-cycle writeback
    issue(5'd3, 1'b1);
    push(K_RDY, "issue_f3_ready", 32'd1);
    drain();
    cyc();
    push(K_CNT, "cnt_after_f3", 32'd1);
    iISSUE_VALID = 1'b1; iISSUE_USES_RS1 = 1'b1; iRS1 = 5'd3;
    push(K_RDY, "raw_rs1_block", 32'd0);
    drain();
    wb(5'd3, 32'h11111111, 5'd0);
    push(K_RDY, "raw_rs1_wb_release", 32'd1);
    drain();
    cyc();
    push(K_CNT, "cnt_after_wb3", 32'd0);
    drain();

    // RAW through rs2/rs3, and unused operand ignored
    issue(5'd9, 1'b1);
    cyc();
    iRS2 = 5'd9; iISSUE_USES_RS2 = 1'b1;
    push(K_RDY, "raw_rs2_block", 32'd0);
    drain();
    iISSUE_USES_RS2 = 1'b0; iRS3 = 5'd9; iISSUE_USES_RS3 = 1'b1;
    push(K_RDY, "raw_rs3_block", 32'd0);
    drain();
    iISSUE_USES_RS3 = 1'b0;
    push(K_RDY, "unused_rs_ok", 32'd1);
    drain();
    wb(5'd9, 32'h0, 5'd0);
    cyc();

    // WAW with coincident writeback: set wins
    issue(5'd7, 1'b1);
    cyc();
    issue(5'd7, 1'b1); wb(5'd7, 32'h22222222, 5'd0);
    push(K_RDY, "waw_wb_release", 32'd1);
    drain();
    cyc();
    push(K_CNT, "set_wins_cnt", 32'd1);
    issue(5'd7, 1'b1);
    push(K_RDY, "waw_block", 32'd0);
    drain();
    cyc();
    push(K_CNT, "blocked_no_set", 32'd1);
    drain();
    wb(5'd7, 32'h33333333, 5'd0);
    cyc();
    push(K_CNT, "waw_cleared", 32'd0);
    iISSUE_RD = 5'd7; iISSUE_WRITES_FRD = 1'b1;
    push(K_RDY, "waw_free", 32'd1);
    drain();

    // Non-pending writeback leaves count at 0
    wb(5'd12, 32'h44444444, 5'd0);
    cyc();
    push(K_CNT, "wb_nonpending_cnt", 32'd0);
    drain();

    // Flag accrual and fcsr write with concurrent accrual
    wb(5'd10, 32'h0, 5'h01);
    cyc();
    wb(5'd10, 32'h0, 5'h04);
    cyc();
    iCSR_ADDR = 12'h001;
    push(K_CSR, "fflags_accrue", 32'h05);
    drain();
    csr_wr(12'h003, 32'hE3); wb(5'd11, 32'h0, 5'h10);
    cyc();
    iCSR_ADDR = 12'h003;
    push(K_CSR, "fcsr_wr_accrue", 32'hF3);
    push(K_FRM, "frm_7", 32'd7);
    push(K_INV, "frm_7_invalid", 32'd1);
    drain();
    iCSR_ADDR = 12'h002;
    push(K_CSR, "frm_read", 32'd7);
    drain();

    // Unmapped CSR write ignored, read returns 0
    csr_wr(12'h004, 32'hFFFFFFFF);
    cyc();
    iCSR_ADDR = 12'h004;
    push(K_CSR, "csr_unmapped", 32'd0);
    drain();
    iCSR_ADDR = 12'h003;
    push(K_CSR, "csr_unchanged", 32'hF3);
    drain();

    // frm boundaries
    csr_wr(12'h002, 32'd2);
    cyc();
    iCSR_ADDR = 12'h002;
    push(K_CSR, "frm_wr_2", 32'd2);
    push(K_INV, "frm_2_valid", 32'd0);
    drain();
    csr_wr(12'h002, 32'd4);
    cyc();
    push(K_INV, "frm_4_valid", 32'd0);
    drain();
    csr_wr(12'h002, 32'd5);
    cyc();
    push(K_INV, "frm_5_invalid", 32'd1);
    push(K_FRM, "frm_5", 32'd5);
    drain();

    // fflags write with concurrent accrual
    csr_wr(12'h001, 32'h0); wb(5'd13, 32'h0, 5'h08);
    cyc();
    iCSR_ADDR = 12'h003;
    push(K_CSR, "fflags_wr_accrue", {24'b0, 3'd5, 5'h08});
    drain();

    // Reset discards concurrent writeback and clears scoreboard
    issue(5'd1, 1'b1);
    cyc();
    issue(5'd2, 1'b1);
    cyc();
    issue(5'd4, 1'b1);
    cyc();
    push(K_CNT, "cnt_three", 32'd3);
    drain();
    iRST = 1'b1; wb(5'd1, 32'h0000DEAD, 5'h1F); issue(5'd6, 1'b1);
    cyc();
    iRS1 = 5'd1; iRS3 = 5'd5; iCSR_ADDR = 12'h003;
    iISSUE_RD = 5'd1; iISSUE_WRITES_FRD = 1'b1;
    iISSUE_USES_RS2 = 1'b1; iRS2 = 5'd2;
    push(K_CNT, "rst2_cnt", 32'd0);
    push(K_RS1, "rst2_f1", 32'd0);
    push(K_RS3, "rst2_f5", 32'd0);
    push(K_CSR, "rst2_fcsr", 32'd0);
    push(K_FRM, "rst2_frm", 32'd0);
    push(K_RDY, "rst2_ready", 32'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
